// File: rtl/rx_bit_timer.sv
// Bit/byte timing generator for the USB RX path: sample strobe per bit, bit and byte counters.
// Optional phase realignment on data edges when RX_TIMER_RESYNC_EN is defined.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_PHASE  = 3,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned BYTE_CNT_W    = 7,
  localparam int unsigned PhW          = $clog2(CLKS_PER_BIT),
  localparam int unsigned BcW          = $clog2(BITS_PER_BYTE)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  enable_timer,
  input  logic                  invalid_bit,
  input  logic                  resync,
  output logic                  shift_enable,
  output logic                  shift_enable_const,
  output logic                  byte_complete,
  output logic [PhW-1:0]        bit_phase,
  output logic [BcW-1:0]        bit_count,
  output logic [BYTE_CNT_W-1:0] byte_count
);

  localparam logic [PhW-1:0]        PhaseMax  = PhW'(CLKS_PER_BIT - 1);
  localparam logic [PhW-1:0]        SamplePh  = PhW'(SAMPLE_PHASE);
  localparam logic [BcW-1:0]        BitMax    = BcW'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_CNT_W-1:0] ByteMax   = '1;

  logic [PhW-1:0]        bit_phase_q, bit_phase_d;
  logic [BcW-1:0]        bit_count_q, bit_count_d;
  logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
  logic                  byte_complete_q, byte_complete_d;
  logic                  run;

`ifndef RX_TIMER_RESYNC_EN
  logic unused_resync;
  assign unused_resync = resync;
`endif

  always_comb begin
    run                = enable_timer & ~invalid_bit;
    shift_enable       = run && (bit_phase_q == SamplePh);
    shift_enable_const = invalid_bit | shift_enable;

    bit_phase_d = bit_phase_q;
    if (!enable_timer) begin
      bit_phase_d = '0;
`ifdef RX_TIMER_RESYNC_EN
    end else if (resync) begin
      // The edge cycle itself counts as phase 0, so the following cycle is phase 1.
      bit_phase_d = PhW'(1);
`endif
    end else if (run) begin
      bit_phase_d = (bit_phase_q == PhaseMax) ? '0 : bit_phase_q + PhW'(1);
    end

    bit_count_d = bit_count_q;
    if (!enable_timer) begin
      bit_count_d = '0;
    end else if (shift_enable) begin
      bit_count_d = (bit_count_q == BitMax) ? '0 : bit_count_q + BcW'(1);
    end

    // Registered regardless of enable so a pending pulse survives enable falling.
    byte_complete_d = shift_enable && (bit_count_q == BitMax);

    byte_count_d = byte_count_q;
    if (!enable_timer) begin
      byte_count_d = '0;
    end else if (byte_complete_q && (byte_count_q != ByteMax)) begin
      byte_count_d = byte_count_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_phase_q     <= '0;
      bit_count_q     <= '0;
      byte_count_q    <= '0;
      byte_complete_q <= 1'b0;
    end else begin
      bit_phase_q     <= bit_phase_d;
      bit_count_q     <= bit_count_d;
      byte_count_q    <= byte_count_d;
      byte_complete_q <= byte_complete_d;
    end
  end

  assign bit_phase     = bit_phase_q;
  assign bit_count     = bit_count_q;
  assign byte_count    = byte_count_q;
  assign byte_complete = byte_complete_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: random stimulus, arithmetic reference model, queued checks.
module tb_rx_bit_timer;

  localparam int unsigned Cpb  = 8;
  localparam int unsigned Sp   = 3;
  localparam int unsigned Bpb  = 8;
  localparam int unsigned Bw   = 3;
  localparam int unsigned PhW  = $clog2(Cpb);
  localparam int unsigned BcW  = $clog2(Bpb);
  localparam int unsigned BMax = (1 << Bw) - 1;

  typedef struct packed {
    logic           se;
    logic           sec;
    logic           bc;
    logic [PhW-1:0] ph;
    logic [BcW-1:0] bits;
    logic [Bw-1:0]  bytes;
  } obs_t;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           enable_timer = 1'b0;
  logic           invalid_bit = 1'b0;
  logic           resync = 1'b0;
  logic           shift_enable, shift_enable_const, byte_complete;
  logic [PhW-1:0] bit_phase;
  logic [BcW-1:0] bit_count;
  logic [Bw-1:0]  byte_count;

  rx_bit_timer #(
    .CLKS_PER_BIT (Cpb),
    .SAMPLE_PHASE (Sp),
    .BITS_PER_BYTE(Bpb),
    .BYTE_CNT_W   (Bw)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .enable_timer      (enable_timer),
    .invalid_bit       (invalid_bit),
    .resync            (resync),
    .shift_enable      (shift_enable),
    .shift_enable_const(shift_enable_const),
    .byte_complete     (byte_complete),
    .bit_phase         (bit_phase),
    .bit_count         (bit_count),
    .byte_count        (byte_count)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference state: run-cycles since enable (or since last edge), strobes, bytes, pending pulse.
  int m_eff = 0, m_bits = 0, m_bytes = 0;
  bit m_bc = 0;

  task automatic step(input bit rst, input bit en, input bit inv, input bit rs);
    obs_t e;
    bit   nbc;
    if (rst) begin
      m_eff = 0; m_bits = 0; m_bytes = 0; m_bc = 0;
    end
    e.ph    = PhW'(m_eff % Cpb);
    e.se    = en && !inv && ((m_eff % Cpb) == Sp);
    e.sec   = inv || e.se;
    e.bc    = m_bc;
    e.bits  = BcW'(m_bits);
    e.bytes = Bw'(m_bytes);
    exp_q.push_back(e);
    if (!rst) begin
      nbc = e.se && (m_bits == Bpb - 1);
      if (e.se) m_bits = (m_bits + 1) % Bpb;
      if (m_bc && en && m_bytes < BMax) m_bytes++;
      if (!en) begin
        m_eff = 0; m_bits = 0; m_bytes = 0;
`ifdef RX_TIMER_RESYNC_EN
      end else if (rs) begin
        m_eff = 1;
`endif
      end else if (!inv) begin
        m_eff++;
      end
      m_bc = nbc;
    end
  endtask

  task automatic cyc(input bit en, input bit inv, input bit rs);
    @(posedge clk);
    #1;
    enable_timer = en; invalid_bit = inv; resync = rs;
    step(!n_rst, en, inv, rs);
  endtask

  task automatic rst_cyc(input bit en);
    @(posedge clk);
    #1;
    n_rst = 1'b0; enable_timer = en; invalid_bit = 1'b0; resync = 1'b0;
    step(1'b1, en, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are settled by the falling edge.
  always @(negedge clk) begin
    obs_t e, a;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{se: shift_enable, sec: shift_enable_const, bc: byte_complete,
            ph: bit_phase, bits: bit_count, bytes: byte_count};
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 20)
          $display("FAIL outputs cyc=%0d got se=%b sec=%b bc=%b ph=%0d bits=%0d bytes=%0d want se=%b sec=%b bc=%b ph=%0d bits=%0d bytes=%0d",
                   cyc_n, a.se, a.sec, a.bc, a.ph, a.bits, a.bytes,
                   e.se, e.sec, e.bc, e.ph, e.bits, e.bytes);
      end
    end
  end

  initial begin
    // Reset with random noise on the data-side inputs.
    for (int i = 0; i < 3; i++) rst_cyc(1'b0);
    @(posedge clk); #1; n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    // Clean packet: first byte, byte_count reaches 1.
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0, 1'b0);
    // Stuffed-bit freeze for 8 clocks mid-byte.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    // Edge pulses at arbitrary phases.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < int'($urandom_range(2, 10)); j++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
    end
    // Saturation of the byte counter.
    for (int i = 0; i < 640; i++) cyc(1'b1, 1'b0, 1'b0);
    // Drop enable mid-byte, then restart.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    // Enable falling right after a final strobe: pulse must still appear.
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 1200; i++)
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    // Asynchronous reset mid-packet.
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0, 1'b0);
    rst_cyc(1'b1);
    rst_cyc(1'b1);
    @(posedge clk); #1; n_rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) cyc(1'b1, $urandom_range(0, 9) == 0, 1'b0);
    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
